mux41_scan: RTL and testbench

- Upstream sequencer for the 8-bit 4:1 data mux. It drives the mux select and steps round-robin through a programmable mask of enabled channels.
- It holds each channel for a programmable dwell time, then captures the mux output.
- Each captured sample goes out as a tagged word under a valid/ready handshake with back-pressure.
- Sits between control logic (start/stop/config) and the mux (o_sel -> mux select, mux y -> i_mux_y).

---
 rtl/mux41_scan.sv | 101 ++++++++++
 tb/tb_mux41_scan.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux41_scan.sv
// mux41_scan: round-robin 4:1 mux sequencer with dwell, capture and valid/ready output.
// Optional MUX41_SCAN_ONESHOT_EN adds i_oneshot for a single pass over enabled channels.
module mux41_scan #(
  parameter int DW      = 8,
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
`ifdef MUX41_SCAN_ONESHOT_EN
  input  logic               i_oneshot,
`endif
  input  logic [3:0]         i_ch_en,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [DW-1:0]      i_mux_y,
  input  logic               i_ready,
  output logic [1:0]         o_sel,
  output logic [DW-1:0]      o_data,
  output logic [1:0]         o_ch,
  output logic               o_valid,
  output logic               o_busy
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_d;
  logic [3:0] mask_q;
  logic [DWELL_W-1:0] dwell_q, cnt;
  logic [1:0] ch, nch, low;
  logic stop_pend, oneshot_q, oneshot_in, go, cap, at_end, last;
`ifdef MUX41_SCAN_ONESHOT_EN
  assign oneshot_in = i_oneshot;
`else
  assign oneshot_in = 1'b0;
`endif
  function automatic logic [1:0] enc(input logic [1:0] c);
    return {c[1], c[1] ^ c[0]};
  endfunction
  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) if (m[k]) r = 2'(k);
    return r;
  endfunction
  // next enabled channel above c, wrapping; returns c itself when it is the only one
  function automatic logic [1:0] next_ch(input logic [1:0] c, input logic [3:0] m);
    logic [1:0] r;
    r = c;
    for (int k = 3; k >= 1; k--) if (m[c + 2'(k)]) r = c + 2'(k);
    return r;
  endfunction
  assign low    = lowest(i_ch_en);
  assign nch    = next_ch(ch, mask_q);
  assign go     = state == IDLE && i_start && |i_ch_en;
  assign at_end = cnt == dwell_q;
  assign cap    = state == SCAN && at_end && (!o_valid || i_ready);
  // a wrap (or a single channel) means ch is the highest enabled channel
  assign last   = stop_pend || (oneshot_q && nch <= ch);
  assign o_busy = state == SCAN;
  always_comb begin
    state_d = go ? SCAN : (cap && last) ? IDLE : state;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      mask_q    <= '0;
      dwell_q   <= '0;
      cnt       <= '0;
      ch        <= '0;
      stop_pend <= 1'b0;
      oneshot_q <= 1'b0;
      o_sel     <= 2'b00;
      o_data    <= '0;
      o_ch      <= 2'b00;
      o_valid   <= 1'b0;
    end else begin
      state <= state_d;
      if (go) begin
        mask_q    <= i_ch_en;
        dwell_q   <= i_dwell;
        cnt       <= '0;
        ch        <= low;
        o_sel     <= enc(low);
        stop_pend <= i_stop;
        oneshot_q <= oneshot_in;
      end else if (cap) begin
        cnt       <= '0;
        ch        <= last ? ch : nch;
        o_sel     <= last ? 2'b00 : enc(nch);
        stop_pend <= last ? 1'b0 : i_stop;
      end else if (state == SCAN) begin
        cnt       <= at_end ? cnt : cnt + DWELL_W'(1);
        stop_pend <= stop_pend | i_stop;
      end
      o_valid <= cap | (o_valid & ~i_ready);
      if (cap) begin
        o_data <= i_mux_y;
        o_ch   <= ch;
      end
    end
  end
endmodule

// File: tb/tb_mux41_scan.sv
// tb_mux41_scan: directed scoreboard bench for mux41_scan with a behavioural 4:1 mux.
module tb_mux41_scan;
  logic clk = 0, rst = 1, start = 0, stop = 0, oneshot = 0, ready = 0;
  logic [3:0] ch_en = 0;
  logic [7:0] dwell = 0, mux_y, data;
  logic [1:0] sel, ch;
  logic valid, busy;
  int checks = 0, errors = 0;
  logic [9:0] q[$];
  logic [1:0] sel_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  always #5 clk = ~clk;
  assign mux_y = (sel == 2'b00) ? 8'h11 : (sel == 2'b01) ? 8'h22 : (sel == 2'b11) ? 8'h33 : 8'h44;
  mux41_scan dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
`ifdef MUX41_SCAN_ONESHOT_EN
    .i_oneshot(oneshot),
`endif
    .i_ch_en(ch_en), .i_dwell(dwell), .i_mux_y(mux_y), .i_ready(ready),
    .o_sel(sel), .o_data(data), .o_ch(ch), .o_valid(valid), .o_busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_scan(input logic [3:0] m, input logic [7:0] d);
    ch_en = m;
    dwell = d;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic push(input logic [1:0] c, input logic [7:0] d);
    q.push_back({c, d});
  endtask
  task automatic drain_and_reset();
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
    ready = 0;
    rst = 1;
    tick();
    rst = 0;
    q.delete();
  endtask
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got ch=%0d data=%0h expected none", ch, data);
      end else begin
        logic [9:0] e;
        e = q.pop_front();
        chk("sample", {ch, data}, e);
      end
    end
  end
  initial begin
    int n;
    tick();
    tick();
    rst = 0;
    chk("rst_out", {sel, data, ch, valid, busy}, 0);
    // full scan
    ready = 1;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
    begin_scan(4'b1111, 8'd2);
    for (int i = 0; i < 12; i++) begin
      chk("fs_sel", sel, sel_tab[i / 3]);
      tick();
    end
    drain_and_reset();
    // sparse mask
    ready = 1;
    for (int i = 0; i < 3; i++) begin push(1, 8'h22); push(3, 8'h44); end
    begin_scan(4'b1010, 8'd0);
    for (int i = 0; i < 6; i++) begin
      chk("sp_sel", sel, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("sp_valid", valid, 1);
      tick();
    end
    drain_and_reset();
    // back-pressure
    ready = 0;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
    begin_scan(4'b1111, 8'd1);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {valid, data, sel}, {1'b1, 8'h11, 2'b01});
      tick();
    end
    ready = 1;
    drain_and_reset();
    // graceful stop during ch2 dwell
    ready = 1;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33);
    begin_scan(4'b1111, 8'd4);
    for (int i = 0; i < 11; i++) tick();
    stop = 1;
    tick();
    stop = 0;
    tick();
    tick();
    chk("st_busy_pre", busy, 1);
    tick();
    chk("st_end", {busy, sel, valid, data}, {1'b0, 2'b00, 1'b1, 8'h33});
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin n += valid; tick(); end
    chk("st_quiet", n, 0);
    chk("st_drained", q.size(), 0);
    begin_scan(4'b0000, 8'd0);
    tick();
    tick();
    chk("mask0_idle", {busy, valid, sel}, 0);
`ifdef MUX41_SCAN_ONESHOT_EN
    ready = 1;
    oneshot = 1;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33);
    begin_scan(4'b0111, 8'd0);
    oneshot = 0;
    tick();
    tick();
    tick();
    chk("os_idle", {busy, sel}, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin n += valid; tick(); end
    chk("os_quiet", n, 0);
    chk("os_drained", q.size(), 0);
`endif
    // reset mid-scan with a sample pending
    ready = 0;
    begin_scan(4'b1111, 8'd0);
    tick();
    tick();
    chk("rs_pre", {valid, busy}, 2'b11);
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rs_out", {sel, data, ch, valid, busy}, 0);
    ready = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin n += valid | busy; tick(); end
    chk("rs_quiet", n, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
